// File: rtl/mina_fetch_q_if.sv
// mina_fetch_q_if: IMEM request/response and IF/ID handshake bundle for the fetch front end
interface mina_fetch_q_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_req;
    logic [31:0] branch_ia;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_ia;
    logic [31:0] id_ia_plus_4;
    logic        draining;
    modport master (
        output imem_req, imem_addr, id_valid, id_ir, id_ia, id_ia_plus_4, draining,
        input  imem_gnt, imem_rvalid, imem_rdata, branch_req, branch_ia, id_ready
    );
    modport slave (
        input  imem_req, imem_addr, id_valid, id_ir, id_ia, id_ia_plus_4, draining,
        output imem_gnt, imem_rvalid, imem_rdata, branch_req, branch_ia, id_ready
    );
endinterface

// File: rtl/mina_fetch_q.sv
// mina_fetch_q: pipelined in-order IMEM fetch with prefetch queue and branch redirect/flush
module mina_fetch_q #(
    parameter logic [31:0] INITIAL_IA = 32'h0000_0000,
    parameter int          QDEPTH     = 4
) (
    input logic            clk,
    input logic            rst,
    mina_fetch_q_if.master bus
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    logic [31:0]   fetch_ia, resp_ia;
    logic [CW-1:0] outstanding, drop, count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   q_ir [QDEPTH];
    logic [31:0]   q_ia [QDEPTH];
    logic          issue, push, pop;

    // Credit rule: queued plus in-flight never exceeds the queue size, so every response has a slot
    assign bus.imem_req     = !rst && !bus.branch_req &&
                              ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(QDEPTH));
    assign bus.imem_addr    = fetch_ia;
    assign issue            = bus.imem_req && bus.imem_gnt;
    assign push             = !rst && bus.imem_rvalid && !bus.branch_req && drop == '0;
    assign pop              = bus.id_valid && bus.id_ready && !bus.branch_req;
    assign bus.id_valid     = count != '0;
    assign bus.id_ir        = q_ir[rd_ptr];
    assign bus.id_ia        = q_ia[rd_ptr];
    assign bus.id_ia_plus_4 = q_ia[rd_ptr] + 32'd4;
    assign bus.draining     = drop != '0;

    // Fetch/response bookkeeping; a branch flushes the queue and marks all in-flight responses stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_ia    <= INITIAL_IA;
            resp_ia     <= INITIAL_IA;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (bus.branch_req) begin
            fetch_ia    <= bus.branch_ia;
            resp_ia     <= bus.branch_ia;
            count       <= '0;
            rd_ptr      <= wr_ptr;
            outstanding <= outstanding - CW'(bus.imem_rvalid);
            drop        <= outstanding - CW'(bus.imem_rvalid);
        end else begin
            if (issue)
                fetch_ia <= fetch_ia + 32'd4;
            outstanding <= outstanding + CW'(issue) - CW'(bus.imem_rvalid);
            if (bus.imem_rvalid && drop != '0)
                drop <= drop - CW'(1);
            if (push) begin
                resp_ia <= resp_ia + 32'd4;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage is not reset; entries are only visible once count covers them
    always_ff @(posedge clk) begin
        if (push) begin
            q_ir[wr_ptr] <= bus.imem_rdata;
            q_ia[wr_ptr] <= resp_ia;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(QDEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(bus.imem_rvalid && outstanding == '0));
    a_credit: assert property (@(posedge clk) disable iff (rst)
                               {1'b0, count} + {1'b0, outstanding} <= (CW+1)'(QDEPTH));
endmodule

// File: tb/tb_mina_fetch_q.sv
// tb_mina_fetch_q: scoreboard bench with an in-order variable-latency IMEM model
module tb_mina_fetch_q;
    localparam int          QD   = 4;
    localparam logic [31:0] INIT = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mina_fetch_q_if bus();
    mina_fetch_q #(.INITIAL_IA(INIT), .QDEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [31:0] p_addr[$];
    int          p_due[$];
    int          p_ep[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch = INIT;
    int epoch = 0, cyc = 0, last_due = 0, lat = 1;
    bit gnt_rand = 0, rdy_rand = 0, lat_rand = 0, gnt_on = 1, rdy_on = 1;
    bit db;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: mode 0 no branch, 1 branch, 2 branch only when rvalid meets a pop
    task automatic cycle(input int mode, input logic [31:0] bia, output bit did);
        int fr, st, q, l;
        logic rv, br, ereq, epop;
        @(negedge clk);
        bus.imem_gnt = gnt_rand ? 1'($urandom_range(1)) : gnt_on;
        bus.id_ready = rdy_rand ? 1'($urandom_range(1)) : rdy_on;
        rv = p_addr.size() > 0 && p_due[0] <= cyc;
        bus.imem_rvalid = rv;
        bus.imem_rdata = rv ? f(p_addr[0]) : 32'h0;
        fr = 0;
        foreach (p_ep[i]) if (p_ep[i] == epoch) fr++;
        st = p_addr.size() - fr;
        q = exp_q.size() - fr;
        br = mode == 1 || (mode == 2 && rv && q > 0 && bus.id_ready);
        did = br;
        bus.branch_req = br;
        bus.branch_ia = bia;
        #1;
        ereq = !br && (exp_q.size() + st < QD);
        chk("req", 32'(bus.imem_req), 32'(ereq));
        chk("id_valid", 32'(bus.id_valid), 32'(q > 0));
        chk("draining", 32'(bus.draining), 32'(st > 0));
        if (ereq)
            chk("imem_addr", bus.imem_addr, exp_fetch);
        epop = q > 0 && bus.id_ready && !br;
        if (epop) begin
            chk("id_ia", bus.id_ia, exp_q[0]);
            chk("id_ir", bus.id_ir, f(exp_q[0]));
            chk("id_ia_plus_4", bus.id_ia_plus_4, exp_q[0] + 32'd4);
            void'(exp_q.pop_front());
        end
        if (rv) begin
            void'(p_addr.pop_front());
            void'(p_due.pop_front());
            void'(p_ep.pop_front());
        end
        if (ereq && bus.imem_gnt) begin
            l = lat_rand ? $urandom_range(1, 4) : lat;
            last_due = (cyc + l > last_due + 1) ? cyc + l : last_due + 1;
            p_addr.push_back(exp_fetch);
            p_due.push_back(last_due);
            p_ep.push_back(epoch);
            exp_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (br) begin
            exp_q.delete();
            exp_fetch = bia;
            epoch++;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, db);
    endtask

    // Stop issuing and let every pending response and queued entry drain, bounded
    task automatic settle();
        gnt_rand = 0; rdy_rand = 0; lat_rand = 0; gnt_on = 0; rdy_on = 1;
        for (int i = 0; i < 100 && (p_addr.size() + exp_q.size()) != 0; i++) cycle(0, 32'h0, db);
        chk("settle", 32'(p_addr.size() + exp_q.size()), 32'h0);
        gnt_on = 1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_valid", 32'(bus.id_valid), 32'h0);
        chk("rst_drain", 32'(bus.draining), 32'h0);
        chk("rst_addr", bus.imem_addr, INIT);
    endtask

    initial begin
        logic [31:0] r;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.branch_req = 1'b0;
        bus.branch_ia = 32'h0;
        bus.id_ready = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        // streaming with 1-cycle responses; first address wraps from INIT to 0
        gnt_on = 1; rdy_on = 1; lat = 1;
        run(12);
        // back-pressure fills the queue, then drains
        rdy_on = 0;
        run(8);
        rdy_on = 1;
        run(8);
        settle();
        // redirect with three responses in flight
        lat = 4;
        run(3);
        cycle(1, 32'h100, db);
        run(14);
        settle();
        // redirect coinciding with a response and a pop
        lat = 2;
        db = 0;
        for (int i = 0; i < 20 && !db; i++) cycle(2, 32'h180, db);
        chk("br_rv_pop_hit", 32'(db), 32'h1);
        run(10);
        settle();
        // second redirect while the first is still draining
        lat = 4;
        run(3);
        cycle(1, 32'h100, db);
        run(1);
        cycle(1, 32'h200, db);
        run(14);
        settle();
        // asynchronous reset with entries queued and requests in flight
        lat = 3; rdy_on = 0;
        run(5);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.branch_req = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        p_addr.delete(); p_due.delete(); p_ep.delete(); exp_q.delete();
        exp_fetch = INIT;
        @(posedge clk);
        cyc++;
        last_due = cyc;
        #1;
        rst = 1'b0;
        rdy_on = 1; lat = 1;
        run(8);
        settle();
        // randomised traffic with occasional redirects
        gnt_rand = 1; rdy_rand = 1; lat_rand = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            r[1:0] = 2'b00;
            cycle(($urandom_range(19) == 0) ? 1 : 0, r, db);
        end
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
